// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - round-robin scheduler sharing one ALU between two requesters
// Optional feature: define SHOW_PREEMPT_EN to let a pending request cut the SHOW hold short.
module alu_sched #(
  parameter int W        = 4,
  parameter int ALU_LAT  = 1,
  parameter int HOLD_CYC = 50000000
) (
  input  logic         clk,
  input  logic         ar,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [1:0]   mode0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [1:0]   mode1,
  output logic         gnt0,
  output logic         gnt1,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_mode,
  input  logic [W+2:0] alu_f,
  input  logic         alu_sign,
  output logic [W+2:0] res,
  output logic         res_sign,
  output logic         res_src,
  output logic         res_valid,
  output logic         busy
);

  localparam int LAT_W  = $clog2(ALU_LAT + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_SHOW} state_t;

  state_t              state;
  state_t              next_state;
  logic                rr_ptr;
  logic [LAT_W-1:0]    lat_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                any_req;
  logic                issue;
  logic                win;
  logic                capture;

  assign any_req   = req0 | req1;
  assign res_valid = (state == S_SHOW);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // rr_ptr holds the last winner, so on a tie the other requester goes first
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    win        = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          issue      = 1'b1;
          win        = (req0 & req1) ? ~rr_ptr : req1;
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: next_state = S_WAIT;
      S_WAIT: begin
        if (lat_cnt == '0) begin
          capture    = 1'b1;
          next_state = S_SHOW;
        end
      end
      S_SHOW: begin
`ifdef SHOW_PREEMPT_EN
        if (any_req || hold_cnt == '0) begin
          next_state = S_IDLE;
        end
`else
        if (hold_cnt == '0) begin
          next_state = S_IDLE;
        end
`endif
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_mode <= '0;
      rr_ptr   <= 1'b1;
      lat_cnt  <= '0;
      hold_cnt <= '0;
      res      <= '0;
      res_sign <= 1'b0;
      res_src  <= 1'b0;
    end else begin
      gnt0 <= issue & ~win;
      gnt1 <= issue & win;
      // operands stay on the ALU until the next grant
      if (issue) begin
        alu_a    <= win ? a1 : a0;
        alu_b    <= win ? b1 : b0;
        alu_mode <= win ? mode1 : mode0;
        rr_ptr   <= win;
      end
      if (state == S_ISSUE) begin
        lat_cnt <= LAT_W'(ALU_LAT - 1);
      end else if (state == S_WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
      if (capture) begin
        res      <= alu_f;
        res_sign <= alu_sign;
        res_src  <= rr_ptr;
        hold_cnt <= HOLD_W'(HOLD_CYC - 1);
      end else if (state == S_SHOW && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

endmodule
